// File: rtl/operand_join_pkg.sv
// Shared constants and helpers for the operand join block and its FIFOs.
// Optional build macro: OPERAND_JOIN_DROP_CNT_EN (drop counter output).
package operand_join_pkg;

    // Default operand width and per-stream FIFO depth (power of two, >= 2).
    localparam int N_DEF     = 16;
    localparam int DEPTH_DEF = 4;
    localparam int AW_DEF    = $clog2(DEPTH_DEF);

    // Dropped-operand counter width and its saturation ceiling.
    localparam int                    DROP_CNT_W   = 8;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = {DROP_CNT_W{1'b1}};

    // Saturating add of 0, 1 or 2 drops to the running drop count.
    function automatic logic [DROP_CNT_W-1:0] drop_cnt_add(
        input logic [DROP_CNT_W-1:0] cur,
        input logic [1:0]            inc
    );
        logic [DROP_CNT_W:0] sum;
        sum = {1'b0, cur} + {{(DROP_CNT_W-1){1'b0}}, inc};
        if (sum > {1'b0, DROP_CNT_MAX}) begin
            return DROP_CNT_MAX;
        end
        return sum[DROP_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/operand_join_fifo.sv
// Single-clock register-array FIFO holding one operand stream.
// push/pop arrive pre-qualified from the top (stall and full already folded
// in), so this block never sees an illegal request. The head is presented
// combinationally so the top can capture it in the same cycle as the pop.
module operand_fifo
    import operand_join_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [N-1:0]               din,
    output logic [N-1:0]               dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

    logic [N-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;

    // Next-state for pointers and occupancy; pointers wrap because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count state; reset empties the FIFO without touching the array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are meaningless once pointers are reset, so no reset here.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == DEPTH_C);

endmodule

// File: rtl/operand_join.sv
// Operand join: buffers two independently timed operand streams and emits
// them as aligned pairs, with R_OUT1/R_OUT2 pulsing together for each pair.
// Optional build macro: OPERAND_JOIN_DROP_CNT_EN adds the DROP_CNT output,
// a saturating count of operands dropped on a full FIFO.
module operand_join
    import operand_join_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  EN,
    input  logic                  R_IN1,
    input  logic [N-1:0]          D_IN1,
    input  logic                  R_IN2,
    input  logic [N-1:0]          D_IN2,
    output logic                  R_OUT1,
    output logic [N-1:0]          D_OUT1,
    output logic                  R_OUT2,
    output logic [N-1:0]          D_OUT2,
    output logic                  FULL1,
    output logic                  FULL2,
    output logic                  OVF
`ifdef OPERAND_JOIN_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0] DROP_CNT
`endif
);

    localparam int AW = $clog2(DEPTH);

    // Per-stream views so both FIFOs can be built and qualified in one loop.
    logic [1:0]   r_in;
    logic [N-1:0] d_in   [2];
    logic [N-1:0] head   [2];
    logic [AW:0]  count  [2];
    logic [1:0]   full;
    logic [1:0]   push;
    logic [1:0]   drop;
    logic         pop;

    assign r_in    = {R_IN2, R_IN1};
    assign d_in[0] = D_IN1;
    assign d_in[1] = D_IN2;

    // A pair leaves only when both streams hold an operand, judged on pre-edge counts.
    assign pop = EN && (count[0] != '0) && (count[1] != '0);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_stream
            // A full FIFO still accepts when a pop frees its head slot this cycle.
            assign push[gi] = EN && r_in[gi] && (!full[gi] || pop);
            assign drop[gi] = EN && r_in[gi] && full[gi] && !pop;

            operand_fifo #(
                .N     (N),
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk   (CLK),
                .rst_n (RST),
                .push  (push[gi]),
                .pop   (pop),
                .din   (d_in[gi]),
                .dout  (head[gi]),
                .count (count[gi]),
                .full  (full[gi])
            );
        end
    endgenerate

    logic         r_out_q,  r_out_d;
    logic [N-1:0] d_out1_q, d_out1_d;
    logic [N-1:0] d_out2_q, d_out2_d;
    logic         ovf_q,    ovf_d;

    // Output pair and sticky overflow; with EN low everything holds, stretching any pulse.
    always_comb begin
        r_out_d  = r_out_q;
        d_out1_d = d_out1_q;
        d_out2_d = d_out2_q;
        ovf_d    = ovf_q;
        if (EN) begin
            r_out_d = pop;
            if (pop) begin
                d_out1_d = head[0];
                d_out2_d = head[1];
            end
            if (drop != 2'b00) begin
                ovf_d = 1'b1;
            end
        end
    end

    // Output registers, cleared asynchronously so a reset kills any pending pulse at once.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_out_q  <= 1'b0;
            d_out1_q <= '0;
            d_out2_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            r_out_q  <= r_out_d;
            d_out1_q <= d_out1_d;
            d_out2_q <= d_out2_d;
            ovf_q    <= ovf_d;
        end
    end

`ifdef OPERAND_JOIN_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    // Count every dropped operand (2 when both streams drop together), saturating at the top.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop != 2'b00) begin
            drop_cnt_d = drop_cnt_add(drop_cnt_q, {drop[0] & drop[1], drop[0] ^ drop[1]});
        end
    end

    // Drop counter register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign DROP_CNT = drop_cnt_q;
`endif

    assign R_OUT1 = r_out_q;
    assign R_OUT2 = r_out_q;
    assign D_OUT1 = d_out1_q;
    assign D_OUT2 = d_out2_q;
    assign FULL1  = full[0];
    assign FULL2  = full[1];
    assign OVF    = ovf_q;

endmodule

// File: tb/tb_operand_join.sv
// Directed bench for operand_join: each accepted operand is queued on a
// per-stream scoreboard when driven; every emitted pair pops both queues.
module tb_operand_join;

    localparam int N     = 16;
    localparam int DEPTH = 4;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         EN  = 1'b0;
    logic         R_IN1 = 1'b0;
    logic [N-1:0] D_IN1 = '0;
    logic         R_IN2 = 1'b0;
    logic [N-1:0] D_IN2 = '0;
    logic         R_OUT1, R_OUT2, FULL1, FULL2, OVF;
    logic [N-1:0] D_OUT1, D_OUT2;
`ifdef OPERAND_JOIN_DROP_CNT_EN
    logic [7:0]   DROP_CNT;
`endif

    operand_join #(.N(N), .DEPTH(DEPTH)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .EN     (EN),
        .R_IN1  (R_IN1),
        .D_IN1  (D_IN1),
        .R_IN2  (R_IN2),
        .D_IN2  (D_IN2),
        .R_OUT1 (R_OUT1),
        .D_OUT1 (D_OUT1),
        .R_OUT2 (R_OUT2),
        .D_OUT2 (D_OUT2),
        .FULL1  (FULL1),
        .FULL2  (FULL2),
        .OVF    (OVF)
`ifdef OPERAND_JOIN_DROP_CNT_EN
        ,
        .DROP_CNT (DROP_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    int           n_cmp  = 0;
    int           n_fail = 0;
    int           pulses = 0;
    logic [N-1:0] sb1 [$];
    logic [N-1:0] sb2 [$];
    logic         exp_r   = 1'b0;
    logic [N-1:0] exp_d1  = '0;
    logic [N-1:0] exp_d2  = '0;
    logic         exp_ovf = 1'b0;
    int           exp_drop = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic en, input logic r1, input logic [N-1:0] d1,
                         input logic r2, input logic [N-1:0] d2);
        EN = en; R_IN1 = r1; D_IN1 = d1; R_IN2 = r2; D_IN2 = d2;
    endtask

    // One clock: update the scoreboard at the edge, check all outputs at the falling edge.
    task automatic step();
        bit pm, acc1, acc2;
        int nd;
        int sz1, sz2;
        @(posedge CLK);
        if (EN) begin
            sz1 = sb1.size();
            sz2 = sb2.size();
            pm   = (sz1 > 0) && (sz2 > 0);
            acc1 = R_IN1 && ((sz1 < DEPTH) || pm);
            acc2 = R_IN2 && ((sz2 < DEPTH) || pm);
            nd   = int'(R_IN1 && !acc1) + int'(R_IN2 && !acc2);
            if (pm) begin
                exp_d1 = sb1.pop_front();
                exp_d2 = sb2.pop_front();
                pulses++;
            end
            if (acc1) sb1.push_back(D_IN1);
            if (acc2) sb2.push_back(D_IN2);
            exp_r = pm;
            if (nd > 0) exp_ovf = 1'b1;
            exp_drop = (exp_drop + nd > 255) ? 255 : exp_drop + nd;
        end
        @(negedge CLK);
        chk("r_out1", R_OUT1, exp_r);
        chk("r_out2", R_OUT2, exp_r);
        chk("d_out1", D_OUT1, exp_d1);
        chk("d_out2", D_OUT2, exp_d2);
        chk("full1", FULL1, sb1.size() == DEPTH);
        chk("full2", FULL2, sb2.size() == DEPTH);
        chk("ovf", OVF, exp_ovf);
`ifdef OPERAND_JOIN_DROP_CNT_EN
        chk("drop_cnt", DROP_CNT, exp_drop);
`endif
        $display("t=%0t en=%b in1=%b/%h in2=%b/%h -> r=%b d1=%h d2=%h f=%b%b ovf=%b",
                 $time, EN, R_IN1, D_IN1, R_IN2, D_IN2, R_OUT1, D_OUT1, D_OUT2,
                 FULL1, FULL2, OVF);
    endtask

    // Asynchronous reset in the middle of the low clock phase; outputs must clear with no edge.
    task automatic async_reset();
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        #2 RST = 1'b0;
        #1;
        chk("rst_r_out1", R_OUT1, 1'b0);
        chk("rst_r_out2", R_OUT2, 1'b0);
        chk("rst_d_out1", D_OUT1, 16'h0);
        chk("rst_d_out2", D_OUT2, 16'h0);
        chk("rst_ovf", OVF, 1'b0);
        chk("rst_full1", FULL1, 1'b0);
        sb1.delete();
        sb2.delete();
        exp_r = 1'b0; exp_d1 = '0; exp_d2 = '0; exp_ovf = 1'b0; exp_drop = 0;
        @(negedge CLK);
        RST = 1'b1;
        pulses = 0;
    endtask

    initial begin
        // Initial reset
        @(negedge CLK);
        async_reset();

        // Test 1: op1 at cycle 0, op2 at cycle 3 -> single pulse (5,3)
        drive(1'b1, 1'b1, 16'h0005, 1'b0, '0); step();
        drive(1'b1, 1'b0, '0, 1'b0, '0);       step(); step();
        chk("t1_no_early_pulse", pulses, 0);
        drive(1'b1, 1'b0, '0, 1'b1, 16'h0003); step();
        drive(1'b1, 1'b0, '0, 1'b0, '0);       step();
        chk("t1_pair_r", R_OUT1, 1'b1);
        chk("t1_pair_d1", D_OUT1, 16'h0005);
        chk("t1_pair_d2", D_OUT2, 16'h0003);
        step(); step();
        chk("t1_pulses", pulses, 1);

        // Test 2: four on stream 1, then four on stream 2 -> four consecutive pairs
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 16'(10 * (i + 1)), 1'b0, '0); step();
        end
        chk("t2_full1", FULL1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, '0, 1'b1, 16'(i + 1)); step();
        end
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        step();
        chk("t2_last_d1", D_OUT1, 16'd40);
        chk("t2_last_d2", D_OUT2, 16'd4);
        step();
        chk("t2_pulses", pulses, 4);
        chk("t2_ovf", OVF, 1'b0);

        // Test 4: FIFO1 full, both strobes high while popping -> no drop, pair every cycle
        async_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 16'h0100 + 16'(i), 1'b0, '0); step();
        end
        drive(1'b1, 1'b0, '0, 1'b1, 16'h0200); step();
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, 16'h0110 + 16'(i), 1'b1, 16'h0210 + 16'(i)); step();
            chk("t4_full1_held", FULL1, 1'b1);
        end
        chk("t4_pulses", pulses, 6);
        chk("t4_ovf", OVF, 1'b0);
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 3; i++) step();

        // Test 5: EN low for 3 cycles during a pending pulse
        async_reset();
        drive(1'b1, 1'b1, 16'h0011, 1'b1, 16'h0022); step();
        drive(1'b1, 1'b1, 16'h0033, 1'b1, 16'h0044); step();
        drive(1'b0, 1'b1, 16'h00EE, 1'b1, 16'h00EE);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_hold_r", R_OUT1, 1'b1);
            chk("t5_hold_d1", D_OUT1, 16'h0011);
        end
        drive(1'b1, 1'b0, '0, 1'b0, '0); step();
        chk("t5_resume_d1", D_OUT1, 16'h0033);
        chk("t5_resume_d2", D_OUT2, 16'h0044);
        step();
        chk("t5_pulses", pulses, 2);
        chk("t5_ovf", OVF, 1'b0);

        // Test 3: overflow on stream 1 -> sticky OVF, dropped value never paired
        async_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 16'(i + 1), 1'b0, '0); step();
        end
        drive(1'b1, 1'b1, 16'h00AA, 1'b0, '0); step();
        chk("t3_ovf_set", OVF, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, '0, 1'b1, 16'h0050 + 16'(i)); step();
            chk("t3_not_aa", (R_OUT1 && D_OUT1 == 16'h00AA), 1'b0);
        end
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        step(); step();
        chk("t3_pulses", pulses, 4);
        chk("t3_ovf_sticky", OVF, 1'b1);

        // Test 6: async reset mid-stream discards queued operands
        async_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 16'h0A00 + 16'(i), 1'b0, '0); step();
        end
        drive(1'b1, 1'b0, '0, 1'b1, 16'h0B00); step();
        drive(1'b1, 1'b0, '0, 1'b1, 16'h0B01); step();
        chk("t6_pair_before_rst", R_OUT1, 1'b1);
        async_reset();
        for (int i = 0; i < 3; i++) step();
        drive(1'b1, 1'b0, '0, 1'b1, 16'h0C00); step();
        drive(1'b1, 1'b0, '0, 1'b0, '0); step(); step();
        chk("t6_no_stale", pulses, 0);
        drive(1'b1, 1'b1, 16'h0D00, 1'b0, '0); step();
        drive(1'b1, 1'b0, '0, 1'b0, '0); step();
        chk("t6_new_d1", D_OUT1, 16'h0D00);
        chk("t6_new_d2", D_OUT2, 16'h0C00);
        step();
        chk("t6_pulses", pulses, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
